// File: rtl/bp_pkg.sv
// Shared types and constants for the back-prop error accumulator.
//   bp_data_t / bp_acc_t : signed contribution and accumulator types of the
//                          default build (32-bit data, 64-bit accumulators).
//   BP_NUM_IN            : lanes per contribution vector.
//   BP_ACC_MAX/BP_ACC_MIN: clamp limits of a default-width accumulator.
//   bp_acc_state_e       : frame FSM states (ACCUM collecting, DONE presenting).
package bp_pkg;

  localparam int BP_NUM_IN      = 32;
  localparam int BP_DATA_W      = 32;
  localparam int BP_ACC_W       = 64;
  localparam int BP_NUM_NEURONS = 8;

  typedef logic signed [BP_DATA_W-1:0] bp_data_t;
  typedef logic signed [BP_ACC_W-1:0]  bp_acc_t;

  localparam bp_acc_t BP_ACC_MAX = {1'b0, {(BP_ACC_W-1){1'b1}}};
  localparam bp_acc_t BP_ACC_MIN = {1'b1, {(BP_ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } bp_acc_state_e;

endpackage

// File: rtl/bp_sat_lane.sv
// One accumulator lane: sign-extends a contribution, adds it to the lane
// accumulator with saturation, and keeps a sticky saturation flag.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   add_en    : accumulate din this cycle
//   clr       : zero accumulator and flag (frame handed off)
//   din       : signed contribution, DATA_W bits
//   acc       : registered accumulator value, ACC_W bits
//   sat       : sticky flag, set when any addition in the frame clamped
module bp_sat_lane #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);

  localparam int EXT_W = ACC_W + 1 - DATA_W;

  logic [ACC_W:0]   sum_w;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [ACC_W-1:0] sum_sat;

  // The sum is formed one bit wider than the accumulator; if the two top
  // bits disagree the true result does not fit and the top bit gives its sign.
  always_comb begin
    sum_w   = {{EXT_W{din[DATA_W-1]}}, din} + {acc[ACC_W-1], acc};
    pos_ovf = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
    neg_ovf =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
    sum_sat = sum_w[ACC_W-1:0];
    if (pos_ovf) begin
      sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (neg_ovf) begin
      sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  // The flag is only ever set during a frame; a later in-range sum moves
  // the value back off the rail but leaves the flag alone.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (add_en) begin
      acc <= sum_sat;
      if (pos_ovf || neg_ovf) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_error_accumulator.sv
// Sums NUM_NEURONS contribution vectors lane-wise with saturation and
// presents the NUM_IN error sums for the previous layer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : contribution vector present
//   in_ready   : vector accepted this cycle (high in ACCUM)
//   in_bc      : packed [NUM_IN-1:0][DATA_W-1:0] contributions
//   out_valid  : sums valid, held until accepted (high in DONE)
//   out_ready  : consumer accepts the sums
//   out_sum    : packed [NUM_IN-1:0][ACC_W-1:0] saturated lane sums
//   out_sat    : per-lane sticky saturation flags for this frame
//   dbg_state  : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its data until that transfer. Both
// in_ready and out_valid decode from the state register only, so neither
// depends combinationally on in_valid or out_ready.
module bp_error_accumulator
  import bp_pkg::*;
#(
  parameter int NUM_IN      = BP_NUM_IN,
  parameter int DATA_W      = BP_DATA_W,
  parameter int ACC_W       = BP_ACC_W,
  parameter int NUM_NEURONS = BP_NUM_NEURONS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN-1:0][DATA_W-1:0] in_bc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_IN-1:0][ACC_W-1:0]  out_sum,
  output logic [NUM_IN-1:0]             out_sat,
  output bp_acc_state_e                 dbg_state
);

  localparam int CNT_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_NEURONS - 1);

  bp_acc_state_e    state;
  bp_acc_state_e    state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_cnt_next;
  logic             add_en;
  logic             clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // The counter holds the number of beats already taken; the beat that
  // arrives while it reads LAST_BEAT completes the frame.
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    add_en        = 1'b0;
    clr           = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          add_en = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_next = '0;
            state_next    = DONE;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clr        = 1'b1;
          state_next = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  assign dbg_state = state;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    bp_sat_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .add_en (add_en),
      .clr    (clr),
      .din    (in_bc[i]),
      .acc    (out_sum[i]),
      .sat    (out_sat[i])
    );
  end

endmodule

// File: tb/tb_bp_error_accumulator.sv
// Bench for bp_error_accumulator. Two instances share every input: the
// default 64-bit build and a 33-bit accumulator build that is easy to drive
// into saturation with 32-bit contributions.
module tb_bp_error_accumulator;
  import bp_pkg::*;

  typedef logic [31:0][31:0] vec_t;
  typedef logic [31:0][63:0] s64_t;
  typedef logic [31:0][32:0] s33_t;
  localparam int W = 32*64 + 32 + 32*33 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  vec_t          in_bc = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, in_ready33, out_valid33;
  s64_t          out_sum;
  s33_t          out_sum33;
  logic [31:0]   out_sat, out_sat33;
  bp_acc_state_e dbg_state, dbg_state33;

  bp_error_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bc(in_bc), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sat(out_sat), .dbg_state(dbg_state)
  );

  bp_error_accumulator #(.ACC_W(33)) dut33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready33),
    .in_bc(in_bc), .out_valid(out_valid33), .out_ready(out_ready),
    .out_sum(out_sum33), .out_sat(out_sat33), .dbg_state(dbg_state33)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  vec_t frm[8];
  int or_mode = 0; // 0: out_ready low, 1: high, 2: random

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_s64(input string name, input s64_t got, input s64_t want);
    int ln = 0;
    for (int i = 31; i >= 0; i--) if (got[i] !== want[i]) ln = i;
    chk($sformatf("%s lane %0d", name, ln), got[ln], want[ln]);
  endtask

  task automatic chk_s33(input string name, input s33_t got, input s33_t want);
    int ln = 0;
    for (int i = 31; i >= 0; i--) if (got[i] !== want[i]) ln = i;
    chk($sformatf("%s lane %0d", name, ln), 64'(got[ln]), 64'(want[ln]));
  endtask

  // ---------------- reference model ----------------
  task automatic sat_add(input logic signed [65:0] a, input logic [31:0] d, input int w,
                         output logic signed [65:0] r, output logic o);
    logic signed [65:0] s, mx, mn, dx;
    dx = {{34{d[31]}}, d};
    s  = a + dx;
    mx = (66'sd1 <<< (w - 1)) - 66'sd1;
    mn = -(66'sd1 <<< (w - 1));
    o  = 1'b1;
    if (s > mx)      r = mx;
    else if (s < mn) r = mn;
    else begin
      r = s;
      o = 1'b0;
    end
  endtask

  task automatic push_model();
    s64_t s64;
    s33_t s33;
    logic [31:0] f64, f33;
    logic signed [65:0] a64, a33;
    logic o;
    f64 = '0;
    f33 = '0;
    for (int ln = 0; ln < 32; ln++) begin
      a64 = '0;
      a33 = '0;
      for (int b = 0; b < 8; b++) begin
        sat_add(a64, frm[b][ln], 64, a64, o);
        if (o) f64[ln] = 1'b1;
        sat_add(a33, frm[b][ln], 33, a33, o);
        if (o) f33[ln] = 1'b1;
      end
      s64[ln] = a64[63:0];
      s33[ln] = a33[32:0];
    end
    exp_q.push_back({s64, f64, s33, f33});
  endtask

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) in_bc[i] = $urandom();
    sync();
  endtask

  task automatic drive_beat(input vec_t v);
    int n = 0;
    bit took = 1'b0;
    in_valid = 1'b1;
    in_bc = v;
    while (!took && n < 200) begin
      @(negedge clk);
      took = in_ready;
      sync();
      n++;
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL beat accept: got no in_ready want accept within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  // Pushes the expected sums, drives all eight beats, then checks that
  // out_valid is up in the cycle right after the last beat.
  task automatic run_frame(input bit gaps);
    int g;
    push_model();
    for (int b = 0; b < 8; b++) begin
      g = 0;
      while (gaps && $urandom_range(0, 1) == 1 && g < 8) begin
        idle();
        g++;
      end
      drive_beat(frm[b]);
    end
    @(negedge clk);
    chk("out_valid after last beat", 64'(out_valid), 64'd1);
    sync();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      sync();
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic clear_frame();
    for (int b = 0; b < 8; b++) frm[b] = '0;
  endtask

  task automatic load_t1();
    clear_frame();
    for (int b = 0; b < 8; b++) begin
      frm[b][0]  = 32'(b + 1);
      frm[b][31] = -32'sd5;
    end
  endtask

  // ---------------- out_ready generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit          hold = 1'b0;
  s64_t        prev_sum;
  s33_t        prev_sum33;
  logic [31:0] prev_sat, prev_sat33;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold && out_valid) begin
        chk_s64("hold sum64", out_sum, prev_sum);
        chk("hold sat64", 64'(out_sat), 64'(prev_sat));
        chk_s33("hold sum33", out_sum33, prev_sum33);
        chk("hold sat33", 64'(out_sat33), 64'(prev_sat33));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected output: got out_valid want none pending");
        end else begin
          s64_t e64;
          s33_t e33;
          logic [31:0] ef64, ef33;
          {e64, ef64, e33, ef33} = exp_q.pop_front();
          chk_s64("sum64", out_sum, e64);
          chk("sat64", 64'(out_sat), 64'(ef64));
          chk("valid33", 64'(out_valid33), 64'd1);
          chk_s33("sum33", out_sum33, e33);
          chk("sat33", 64'(out_sat33), 64'(ef33));
        end
      end
      hold       = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_sat   = out_sat;
      prev_sum33 = out_sum33;
      prev_sat33 = out_sat33;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    s64_t h64;
    s33_t h33;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset state", 64'(dbg_state), 64'(ACCUM));
    chk_s64("reset sum64", out_sum, '0);
    chk("reset sat64", 64'(out_sat), 64'd0);
    chk_s33("reset sum33", out_sum33, '0);
    sync();

    // Frame 1: lane 0 = 1..8, lane 31 = -5 x8; held in DONE for inspection.
    or_mode = 0;
    load_t1();
    run_frame(1'b0);
    @(negedge clk);
    h64 = '0;
    h64[0]  = 64'd36;
    h64[31] = 64'hFFFF_FFFF_FFFF_FFD8;
    h33 = '0;
    h33[0]  = 33'd36;
    h33[31] = 33'h1_FFFF_FFD8;
    chk_s64("t1 sum64", out_sum, h64);
    chk_s33("t1 sum33", out_sum33, h33);
    chk("t1 sat64", 64'(out_sat), 64'd0);
    chk("t1 sat33", 64'(out_sat33), 64'd0);
    sync();

    // Backpressure: next frame's first beat offered while DONE stalls.
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 32; i++) frm[b][i] = 32'(i * (b + 1)) - 32'd50;
    in_valid = 1'b1;
    in_bc = frm[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t2 in_ready stalled", 64'(in_ready), 64'd0);
      chk("t2 out_valid held", 64'(out_valid), 64'd1);
    end
    or_mode = 1;
    sync();
    run_frame(1'b0);
    drain();

    // Saturation: lane 3 to ACC_MAX-10 (33-bit) then +0x7FFFFFFF;
    // lane 5 clamps then comes back in range, flag stays.
    or_mode = 0;
    clear_frame();
    frm[0][3] = 32'h7FFF_FFFF;
    frm[1][3] = 32'h7FFF_FFFF;
    frm[2][3] = 32'hFFFF_FFF7;
    frm[3][3] = 32'h7FFF_FFFF;
    frm[0][5] = 32'h7FFF_FFFF;
    frm[1][5] = 32'h7FFF_FFFF;
    frm[2][5] = 32'h7FFF_FFFF;
    frm[3][5] = 32'h8000_0000;
    run_frame(1'b0);
    @(negedge clk);
    chk("t3 sum33 lane3", 64'(out_sum33[3]), 64'h0_FFFF_FFFF);
    chk("t3 sum33 lane5", 64'(out_sum33[5]), 64'h0_7FFF_FFFF);
    chk("t3 sat33", 64'(out_sat33), 64'h28);
    chk("t3 sum64 lane3", out_sum[3], 64'h1_7FFF_FFF4);
    chk("t3 sum64 lane5", out_sum[5], 64'h0_FFFF_FFFD);
    chk("t3 sat64", 64'(out_sat), 64'd0);
    or_mode = 1;
    sync();
    drain();
    @(negedge clk);
    chk("t3 sat33 cleared", 64'(out_sat33), 64'd0);
    chk("t3 lane3 cleared", 64'(out_sum33[3]), 64'd0);
    sync();

    // Negative clamp on every lane of the 33-bit build.
    or_mode = 0;
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 32; i++) frm[b][i] = 32'h8000_0000;
    run_frame(1'b0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      h33[i] = 33'h1_0000_0000;
      h64[i] = 64'hFFFF_FFFC_0000_0000;
    end
    chk_s33("t4 sum33", out_sum33, h33);
    chk("t4 sat33", 64'(out_sat33), 64'hFFFF_FFFF);
    chk_s64("t4 sum64", out_sum, h64);
    chk("t4 sat64", 64'(out_sat), 64'd0);
    or_mode = 1;
    sync();
    drain();

    // Reset after beat 5 of 8 discards the partial frame.
    for (int b = 0; b < 5; b++) begin
      vec_t v;
      for (int i = 0; i < 32; i++) v[i] = 32'(1000 + i + b);
      drive_beat(v);
    end
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("t5 out_valid", 64'(out_valid), 64'd0);
    chk("t5 in_ready", 64'(in_ready), 64'd1);
    chk_s64("t5 sum64 zero", out_sum, '0);
    chk_s33("t5 sum33 zero", out_sum33, '0);
    sync();
    load_t1();
    run_frame(1'b0);
    drain();

    // Random gaps on both sides.
    or_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      for (int b = 0; b < 8; b++)
        for (int i = 0; i < 32; i++) frm[b][i] = $urandom();
      run_frame(1'b1);
    end
    or_mode = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
